// File: rtl/cpu_test_ctrl_if.sv
// =============================================================================
// cpu_test_ctrl_if : cpu data-memory and register-file write ports seen by the test controller
// Revision 1.0
// =============================================================================
`default_nettype none

interface cpu_test_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    modport master (
        output dmem_we, dmem_addr, dmem_wdata,
        output rf_we, rf_waddr, rf_wdata
    );

    modport slave (
        input dmem_we, dmem_addr, dmem_wdata,
        input rf_we, rf_waddr, rf_wdata
    );
endinterface

`default_nettype wire

// File: rtl/cpu_test_ctrl.sv
// =============================================================================
// cpu_test_ctrl : cpu reset sequencing, run counters, tohost end-of-test and watchdog
// Optional retire trace ring buffer with CPU_TEST_CTRL_TRACE_EN.  Revision 1.0
// =============================================================================
`default_nettype none

module cpu_test_ctrl #(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned TIMEOUT      = 25000,
    parameter int unsigned TOHOST_ADDR  = 32'h00001000,
    parameter int          ADDR_W       = 32,
    parameter int          DATA_W       = 32,
    parameter int          CNT_W        = 32,
    parameter int          TRACE_DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    output logic                           cpu_rst,
    cpu_test_ctrl_if.slave                 cpu,
    output logic [CNT_W-1:0]               cycle_cnt,
    output logic [CNT_W-1:0]               retire_cnt,
    output logic                           done,
    output logic                           pass,
    output logic                           timeout,
    output logic [DATA_W-1:0]              exit_code,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [4+DATA_W:0]              trace_data
);

    localparam int                HOLD_W       = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] TOHOST       = ADDR_W'(TOHOST_ADDR);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_TOUT = 3'd4
    } state_t;

    state_t            state;
    logic [HOLD_W-1:0] hold_cnt;
    logic              tohost_hit;
    logic              retire;

    assign tohost_hit = cpu.dmem_we && (cpu.dmem_addr == TOHOST);
    assign retire     = (state == S_RUN) && cpu.rf_we && (cpu.rf_waddr != 5'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            hold_cnt   <= '0;
            cpu_rst    <= 1'b1;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            exit_code  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_TOUT: begin
                    if (start) begin
                        state      <= S_HOLD;
                        hold_cnt   <= '0;
                        cpu_rst    <= 1'b1;
                        cycle_cnt  <= '0;
                        retire_cnt <= '0;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        timeout    <= 1'b0;
                        exit_code  <= '0;
                    end
                end
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state   <= S_RUN;
                        cpu_rst <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_RUN: begin
                    if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
                    if (retire && retire_cnt != '1) retire_cnt <= retire_cnt + CNT_W'(1);
                    // A store in the final watchdog cycle still counts as a finished test
                    if (tohost_hit) begin
                        state     <= S_DONE;
                        cpu_rst   <= 1'b1;
                        done      <= 1'b1;
                        exit_code <= cpu.dmem_wdata;
                        pass      <= (cpu.dmem_wdata == DATA_W'(1));
                    end else if (cycle_cnt == TIMEOUT_LAST) begin
                        state   <= S_TOUT;
                        cpu_rst <= 1'b1;
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    cpu_rst <= 1'b1;
                end
            endcase
        end
    end

`ifdef CPU_TEST_CTRL_TRACE_EN
    localparam int IDX_W = $clog2(TRACE_DEPTH);

    logic [4+DATA_W:0] trace_mem [TRACE_DEPTH];
    logic [IDX_W-1:0]  wptr;
    logic [IDX_W-1:0]  rd_ptr;
    logic              start_ok;

    assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_TOUT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
        end else if (start_ok) begin
            wptr <= '0;
            for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
        end else if (retire) begin
            trace_mem[wptr] <= {cpu.rf_waddr, cpu.rf_wdata};
            wptr            <= wptr + IDX_W'(1);
        end
    end

    // Index 0 is the most recent entry; pointer arithmetic wraps at the power-of-2 depth
    assign rd_ptr     = wptr - IDX_W'(1) - trace_idx;
    assign trace_data = trace_mem[rd_ptr];
`else
    logic unused_trace;

    assign unused_trace = ^{trace_idx, cpu.rf_wdata};
    assign trace_data   = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_cpu_test_ctrl.sv
// =============================================================================
// tb_cpu_test_ctrl : randomized self-checking bench for cpu_test_ctrl with a run-level reference model
// Revision 1.0
// =============================================================================
`default_nettype none

module tb_cpu_test_ctrl;
    localparam int          RC     = 4;
    localparam int          TO     = 20;
    localparam int          TD     = 8;
    localparam logic [31:0] TOHOST = 32'h0000_1000;
`ifdef CPU_TEST_CTRL_TRACE_EN
    localparam bit TRACE_ON = 1'b1;
`else
    localparam bit TRACE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, cpu_rst, done, pass, timeout;
    logic [31:0] cycle_cnt, retire_cnt, exit_code;
    logic [2:0]  trace_idx;
    logic [36:0] trace_data;
    int          checks = 0;
    int          failures = 0;

    // Reference model: phase 0 idle, 1 hold, 2 run, 3 finished
    int          m_phase;
    int          m_hold_left;
    logic [31:0] m_cycles, m_retire, m_exit;
    logic        m_done, m_pass, m_timeout;
    logic [36:0] m_trace [$];

    always #5 clk = ~clk;

    cpu_test_ctrl_if #(.ADDR_W(32), .DATA_W(32)) cpu_bus ();

    cpu_test_ctrl #(
        .RESET_CYCLES(RC), .TIMEOUT(TO), .TOHOST_ADDR(TOHOST),
        .ADDR_W(32), .DATA_W(32), .CNT_W(32), .TRACE_DEPTH(TD)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cpu_rst(cpu_rst), .cpu(cpu_bus),
        .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .done(done), .pass(pass),
        .timeout(timeout), .exit_code(exit_code), .trace_idx(trace_idx), .trace_data(trace_data)
    );

    function automatic void model_clear();
        m_cycles  = '0;
        m_retire  = '0;
        m_exit    = '0;
        m_done    = 1'b0;
        m_pass    = 1'b0;
        m_timeout = 1'b0;
        m_trace.delete();
    endfunction

    function automatic logic [36:0] exp_trace(int idx);
        return (TRACE_ON && idx < m_trace.size()) ? m_trace[idx] : 37'd0;
    endfunction

    task automatic idle_bus();
        cpu_bus.dmem_we    = 1'b0;
        cpu_bus.dmem_addr  = '0;
        cpu_bus.dmem_wdata = '0;
        cpu_bus.rf_we      = 1'b0;
        cpu_bus.rf_waddr   = '0;
        cpu_bus.rf_wdata   = '0;
    endtask

    // One clock: the model consumes the inputs present at the rising edge
    task automatic tick();
        bit last;
        @(posedge clk);
        case (m_phase)
            0, 3: if (start) begin
                model_clear();
                m_phase     = 1;
                m_hold_left = RC;
            end
            1: begin
                m_hold_left--;
                if (m_hold_left == 0) m_phase = 2;
            end
            2: begin
                last     = (m_cycles == 32'(TO - 1));
                m_cycles = m_cycles + 1;
                if (cpu_bus.rf_we && cpu_bus.rf_waddr != 0) begin
                    m_retire = m_retire + 1;
                    m_trace.push_front({cpu_bus.rf_waddr, cpu_bus.rf_wdata});
                    if (m_trace.size() > TD) void'(m_trace.pop_back());
                end
                if (cpu_bus.dmem_we && cpu_bus.dmem_addr == TOHOST) begin
                    m_done  = 1'b1;
                    m_exit  = cpu_bus.dmem_wdata;
                    m_pass  = (cpu_bus.dmem_wdata == 32'd1);
                    m_phase = 3;
                end else if (last) begin
                    m_timeout = 1'b1;
                    m_phase   = 3;
                end
            end
            default: ;
        endcase
        @(negedge clk);
    endtask

    task automatic launch();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (RC) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; trace_idx = 3'd0;
        idle_bus();
        repeat (2) @(negedge clk);
        m_phase = 0;
        model_clear();
        checks++;
        if ({cpu_rst, done, pass, timeout} !== 4'b1000) begin
            failures++;
            $display("FAIL reset_flags: got rst/done/pass/tout=%b required 1000", {cpu_rst, done, pass, timeout});
        end
        checks++;
        if (cycle_cnt !== 0 || retire_cnt !== 0 || exit_code !== 0 || trace_data !== 0) begin
            failures++;
            $display("FAIL reset_values: got cyc=%0d ret=%0d exit=%h trace=%h required all 0",
                     cycle_cnt, retire_cnt, exit_code, trace_data);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (cpu_rst !== 1'b1 || cycle_cnt !== 0) begin
            failures++;
            $display("FAIL idle_no_start: got cpu_rst=%b cyc=%0d required 1 and 0", cpu_rst, cycle_cnt);
        end
    endtask

    task automatic test_hold_sequence();
        logic [31:0] exp_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            exp_cnt = (c <= 5) ? 32'd0 : 32'(c - 5);
            checks++;
            if (cpu_rst !== (c <= 4) || cycle_cnt !== exp_cnt) begin
                failures++;
                $display("FAIL hold_seq c%0d: got cpu_rst=%b cyc=%0d required %b %0d",
                         c, cpu_rst, cycle_cnt, (c <= 4), exp_cnt);
            end
            start = (c == 2 || c == 6);
            tick();
            start = 1'b0;
        end
    endtask

    task automatic test_pass_store();
        logic [4:0]  wa [3] = '{5'd0, 5'd5, 5'd6};
        logic [31:0] wd [3] = '{32'd5, 32'd3, 32'd9};
        logic [36:0] t0, t1;
        for (int i = 0; i < 3; i++) begin
            cpu_bus.rf_we = 1'b1; cpu_bus.rf_waddr = wa[i]; cpu_bus.rf_wdata = wd[i];
            tick();
        end
        idle_bus();
        cpu_bus.dmem_we = 1'b1; cpu_bus.dmem_addr = TOHOST; cpu_bus.dmem_wdata = 32'd1;
        tick();
        idle_bus();
        checks++;
        if ({done, pass, timeout, cpu_rst} !== 4'b1101 || exit_code !== 32'd1) begin
            failures++;
            $display("FAIL pass_store: got done/pass/tout/cpu_rst=%b exit=%h required 1101 exit=1",
                     {done, pass, timeout, cpu_rst}, exit_code);
        end
        checks++;
        if (retire_cnt !== 32'd2 || cycle_cnt !== m_cycles) begin
            failures++;
            $display("FAIL retire_count: got ret=%0d cyc=%0d required 2 %0d", retire_cnt, cycle_cnt, m_cycles);
        end
        t0 = TRACE_ON ? {5'd6, 32'd9} : 37'd0;
        t1 = TRACE_ON ? {5'd5, 32'd3} : 37'd0;
        trace_idx = 3'd0; #1;
        checks++;
        if (trace_data !== t0) begin
            failures++;
            $display("FAIL trace_newest: got %h required %h", trace_data, t0);
        end
        trace_idx = 3'd1; #1;
        checks++;
        if (trace_data !== t1) begin
            failures++;
            $display("FAIL trace_second: got %h required %h", trace_data, t1);
        end
        repeat (3) begin
            cpu_bus.rf_we = 1'b1; cpu_bus.rf_waddr = 5'd9; cpu_bus.rf_wdata = $urandom;
            cpu_bus.dmem_we = 1'b1; cpu_bus.dmem_addr = TOHOST; cpu_bus.dmem_wdata = $urandom;
            tick();
        end
        idle_bus();
        checks++;
        if (cycle_cnt !== m_cycles || retire_cnt !== 32'd2 || exit_code !== 32'd1 || done !== 1'b1) begin
            failures++;
            $display("FAIL done_frozen: got cyc=%0d ret=%0d exit=%h done=%b required %0d 2 1 1",
                     cycle_cnt, retire_cnt, exit_code, done, m_cycles);
        end
    endtask

    task automatic test_fail_code();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, pass, timeout, cpu_rst} !== 4'b0001 || exit_code !== 0 || cycle_cnt !== 0 || retire_cnt !== 0) begin
            failures++;
            $display("FAIL restart_clear: got done/pass/tout/cpu_rst=%b exit=%h cyc=%0d ret=%0d required 0001 0 0 0",
                     {done, pass, timeout, cpu_rst}, exit_code, cycle_cnt, retire_cnt);
        end
        repeat (RC) tick();
        cpu_bus.dmem_we = 1'b1; cpu_bus.dmem_addr = TOHOST + 32'd4; cpu_bus.dmem_wdata = 32'd1;
        tick();
        checks++;
        if (done !== 1'b0 || cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL wrong_addr: got done=%b cpu_rst=%b required 0 0", done, cpu_rst);
        end
        cpu_bus.dmem_addr = TOHOST; cpu_bus.dmem_wdata = 32'd7;
        tick();
        idle_bus();
        checks++;
        if ({done, pass, timeout} !== 3'b100 || exit_code !== 32'd7) begin
            failures++;
            $display("FAIL exit_code7: got done/pass/tout=%b exit=%h required 100 7", {done, pass, timeout}, exit_code);
        end
    endtask

    task automatic test_timeout();
        launch();
        for (int i = 0; i < TO + 4 && m_phase == 2; i++) begin
            cpu_bus.rf_we = $urandom_range(0, 1); cpu_bus.rf_waddr = 5'($urandom); cpu_bus.rf_wdata = $urandom;
            tick();
        end
        idle_bus();
        checks++;
        if ({timeout, done, pass, cpu_rst} !== 4'b1001 || cycle_cnt !== 32'(TO)) begin
            failures++;
            $display("FAIL timeout: got tout/done/pass/cpu_rst=%b cyc=%0d required 1001 %0d",
                     {timeout, done, pass, cpu_rst}, cycle_cnt, TO);
        end
        launch();
        repeat (TO - 1) tick();
        checks++;
        if (cycle_cnt !== 32'(TO - 1) || timeout !== 1'b0 || cpu_rst !== 1'b0) begin
            failures++;
            $display("FAIL pre_expiry: got cyc=%0d tout=%b cpu_rst=%b required %0d 0 0", cycle_cnt, timeout, cpu_rst, TO - 1);
        end
        cpu_bus.dmem_we = 1'b1; cpu_bus.dmem_addr = TOHOST; cpu_bus.dmem_wdata = 32'd1;
        tick();
        idle_bus();
        checks++;
        if ({done, timeout, pass} !== 3'b101 || cycle_cnt !== 32'(TO)) begin
            failures++;
            $display("FAIL done_wins: got done/tout/pass=%b cyc=%0d required 101 %0d", {done, timeout, pass}, cycle_cnt, TO);
        end
    endtask

    task automatic test_trace_wrap();
        launch();
        for (int i = 0; i < 10; i++) begin
            cpu_bus.rf_we = 1'b1; cpu_bus.rf_waddr = 5'($urandom_range(1, 31)); cpu_bus.rf_wdata = $urandom;
            tick();
        end
        idle_bus();
        cpu_bus.dmem_we = 1'b1; cpu_bus.dmem_addr = TOHOST; cpu_bus.dmem_wdata = 32'd1;
        tick();
        idle_bus();
        checks++;
        if (retire_cnt !== 32'd10) begin
            failures++;
            $display("FAIL wrap_retire: got %0d required 10", retire_cnt);
        end
        for (int k = 0; k < TD; k++) begin
            trace_idx = 3'(k); #1;
            checks++;
            if (trace_data !== exp_trace(k)) begin
                failures++;
                $display("FAIL trace_wrap idx%0d: got %h required %h", k, trace_data, exp_trace(k));
            end
        end
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 6; r++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            for (int c = 0; c < 3 * TO; c++) begin
                cpu_bus.rf_we      = $urandom_range(0, 1);
                cpu_bus.rf_waddr   = 5'($urandom);
                cpu_bus.rf_wdata   = $urandom;
                cpu_bus.dmem_we    = ($urandom_range(0, 9) == 0);
                case ($urandom_range(0, 2))
                    0:       cpu_bus.dmem_addr = TOHOST;
                    1:       cpu_bus.dmem_addr = TOHOST + 32'd4;
                    default: cpu_bus.dmem_addr = $urandom;
                endcase
                cpu_bus.dmem_wdata = ($urandom_range(0, 2) == 0) ? 32'd1 : 32'($urandom_range(0, 3));
                start              = ($urandom_range(0, 19) == 0);
                trace_idx          = 3'($urandom);
                #1;
                checks++;
                if (cpu_rst !== (m_phase != 2) || done !== m_done || pass !== m_pass || timeout !== m_timeout ||
                    cycle_cnt !== m_cycles || retire_cnt !== m_retire || exit_code !== m_exit ||
                    trace_data !== exp_trace(int'(trace_idx))) begin
                    failures++;
                    $display("FAIL random r%0d c%0d: got rst=%b done=%b pass=%b tout=%b cyc=%0d ret=%0d exit=%h trace=%h required %b %b %b %b %0d %0d %h %h",
                             r, c, cpu_rst, done, pass, timeout, cycle_cnt, retire_cnt, exit_code, trace_data,
                             (m_phase != 2), m_done, m_pass, m_timeout, m_cycles, m_retire, m_exit, exp_trace(int'(trace_idx)));
                end
                tick();
            end
        end
        start = 1'b0;
        idle_bus();
        for (int i = 0; i < TO + RC + 2 && (m_phase == 1 || m_phase == 2); i++) tick();
    endtask

    task automatic test_rst_midrun();
        launch();
        repeat (3) begin
            cpu_bus.rf_we = 1'b1; cpu_bus.rf_waddr = 5'd7; cpu_bus.rf_wdata = $urandom;
            tick();
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cpu_rst, done, pass, timeout} !== 4'b1000 || cycle_cnt !== 0 || retire_cnt !== 0 ||
            exit_code !== 0 || trace_data !== 0) begin
            failures++;
            $display("FAIL async_rst: got rst/done/pass/tout=%b cyc=%0d ret=%0d exit=%h trace=%h required 1000 and zeros",
                     {cpu_rst, done, pass, timeout}, cycle_cnt, retire_cnt, exit_code, trace_data);
        end
        m_phase = 0;
        model_clear();
        idle_bus();
        @(negedge clk);
        rst = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= RC + 1; c++) begin
            checks++;
            if (cpu_rst !== (c <= RC) || cycle_cnt !== 0) begin
                failures++;
                $display("FAIL post_rst_hold c%0d: got cpu_rst=%b cyc=%0d required %b 0", c, cpu_rst, cycle_cnt, (c <= RC));
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_hold_sequence();
        test_pass_store();
        test_fail_code();
        test_timeout();
        test_trace_wrap();
        test_random_runs();
        test_rst_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

`default_nettype wire
